// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: tracker entry layout,
// memory-wait FSM states and the hard-wired zero register.
package hazard_pkg;

    localparam int unsigned HZ_REG_AW = 5;
    localparam logic [HZ_REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [HZ_REG_AW-1:0] rd;
        logic                 wr;
        logic                 is_load;
    } track_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode/execute-side signal bundle of the hazard unit; the pipeline drives it as master,
// the hazard unit consumes it as slave.
interface hazard_fwd_unit_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_STAGES = 3,
    parameter int unsigned CNT_W      = 32
);
    logic                       id_valid;
    logic [REG_AW-1:0]          id_rs1;
    logic [REG_AW-1:0]          id_rs2;
    logic                       id_rs1_used;
    logic                       id_rs2_used;
    logic [REG_AW-1:0]          id_rd;
    logic                       id_reg_write;
    logic                       id_is_load;
    logic [XLEN-1:0]            id_op_a;
    logic [XLEN-1:0]            id_op_b;
    logic [FWD_STAGES*XLEN-1:0] stage_data;
    logic                       ex_redirect;
    logic                       dmem_req;
    logic                       dmem_valid;

    logic [XLEN-1:0]            op_a;
    logic [XLEN-1:0]            op_b;
    logic                       fwd_hit_a;
    logic                       fwd_hit_b;
    logic                       hold_front;
    logic                       bubble_ex;
    logic                       flush_front;
    logic                       freeze;
    logic [CNT_W-1:0]           stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
               id_is_load, id_op_a, id_op_b, stage_data, ex_redirect, dmem_req, dmem_valid,
        input  op_a, op_b, fwd_hit_a, fwd_hit_b, hold_front, bubble_ex, flush_front, freeze,
               stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
               id_is_load, id_op_a, id_op_b, stage_data, ex_redirect, dmem_req, dmem_valid,
        output op_a, op_b, fwd_hit_a, fwd_hit_b, hold_front, bubble_ex, flush_front, freeze,
               stall_cycles
    );

endinterface

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: the youngest forwardable matching slot wins; a load
// match in a slot whose data is not ready yet is reported as a load-use hazard.
module fwd_mux
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned FWD_STAGES     = 3,
    parameter int unsigned LOAD_FWD_STAGE = 1
) (
    input  track_entry_t [FWD_STAGES-1:0] i_entries,
    input  logic [FWD_STAGES*XLEN-1:0]    i_stage_data,
    input  logic [REG_AW-1:0]             i_rs,
    input  logic                          i_rs_used,
    input  logic [XLEN-1:0]               i_id_op,
    output logic [XLEN-1:0]               o_op,
    output logic                          o_hit,
    output logic                          o_load_use
);

    logic [HZ_REG_AW-1:0] w_rs;
    logic                 w_match;

    assign w_rs = HZ_REG_AW'(i_rs);

    always_comb begin
        o_op       = i_id_op;
        o_hit      = 1'b0;
        o_load_use = 1'b0;
        w_match    = 1'b0;
        // Walk oldest to youngest so the youngest forwardable match is the last write.
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            w_match = i_entries[i].valid && i_entries[i].wr && (i_entries[i].rd == w_rs) &&
                      (w_rs != REG_ZERO) && i_rs_used;
            if (w_match && i_entries[i].is_load && (i < int'(LOAD_FWD_STAGE))) begin
                o_load_use = 1'b1;
            end else if (w_match) begin
                o_op  = i_stage_data[i*XLEN +: XLEN];
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller: destination tracker, operand forwarding,
// load-use stall, redirect flush, data-memory wait freeze and stall counter.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned FWD_STAGES     = 3,
    parameter int unsigned LOAD_FWD_STAGE = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_fwd_unit_if.slave bus
);

    track_entry_t [FWD_STAGES-1:0] r_track;
    mem_state_e                    r_state;
    logic [CNT_W-1:0]              r_stall_cnt;

    track_entry_t w_id_entry;
    logic         w_lu_a;
    logic         w_lu_b;
    logic         w_freeze;
    logic         w_redirect;
    logic         w_hold;
    logic         w_bubble;

    fwd_mux #(
        .XLEN           (XLEN),
        .REG_AW         (REG_AW),
        .FWD_STAGES     (FWD_STAGES),
        .LOAD_FWD_STAGE (LOAD_FWD_STAGE)
    ) u_fwd_a (
        .i_entries    (r_track),
        .i_stage_data (bus.stage_data),
        .i_rs         (bus.id_rs1),
        .i_rs_used    (bus.id_rs1_used),
        .i_id_op      (bus.id_op_a),
        .o_op         (bus.op_a),
        .o_hit        (bus.fwd_hit_a),
        .o_load_use   (w_lu_a)
    );

    fwd_mux #(
        .XLEN           (XLEN),
        .REG_AW         (REG_AW),
        .FWD_STAGES     (FWD_STAGES),
        .LOAD_FWD_STAGE (LOAD_FWD_STAGE)
    ) u_fwd_b (
        .i_entries    (r_track),
        .i_stage_data (bus.stage_data),
        .i_rs         (bus.id_rs2),
        .i_rs_used    (bus.id_rs2_used),
        .i_id_op      (bus.id_op_b),
        .o_op         (bus.op_b),
        .o_hit        (bus.fwd_hit_b),
        .o_load_use   (w_lu_b)
    );

    // Priority freeze > redirect > load-use; a redirect discards the stalled ID instruction.
    always_comb begin
        w_freeze   = (r_state == IDLE) ? (bus.dmem_req & ~bus.dmem_valid) : ~bus.dmem_valid;
        w_redirect = bus.ex_redirect & ~w_freeze;
        w_hold     = (w_lu_a | w_lu_b) & ~w_redirect & ~w_freeze;
        w_bubble   = w_hold | w_redirect;
        w_id_entry = '0;
        if (bus.id_valid && !w_bubble) begin
            w_id_entry.valid   = 1'b1;
            w_id_entry.rd      = HZ_REG_AW'(bus.id_rd);
            w_id_entry.wr      = bus.id_reg_write;
            w_id_entry.is_load = bus.id_is_load;
        end
    end

    assign bus.freeze       = w_freeze;
    assign bus.flush_front  = w_redirect;
    assign bus.hold_front   = w_hold;
    assign bus.bubble_ex    = w_bubble;
    assign bus.stall_cycles = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_track     <= '0;
            r_state     <= IDLE;
            r_stall_cnt <= '0;
        end else begin
            if (!w_freeze) begin
                r_track[0] <= w_id_entry;
                for (int i = 1; i < FWD_STAGES; i++) begin
                    r_track[i] <= r_track[i-1];
                end
            end
            case (r_state)
                IDLE:    if (bus.dmem_req && !bus.dmem_valid) r_state <= WAIT;
                WAIT:    if (bus.dmem_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if ((w_hold || w_freeze) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based pipeline model.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned FWD_STAGES = 3;
    localparam int unsigned CNT_W      = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(
        .XLEN       (XLEN),
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .CNT_W      (CNT_W)
    ) bus ();

    hazard_fwd_unit #(
        .XLEN           (XLEN),
        .REG_AW         (REG_AW),
        .FWD_STAGES     (FWD_STAGES),
        .LOAD_FWD_STAGE (1),
        .CNT_W          (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid     = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2_used  = 1'b0;
        bus.id_rd        = '0;
        bus.id_reg_write = 1'b0;
        bus.id_is_load   = 1'b0;
        bus.id_op_a      = 32'hAAAA;
        bus.id_op_b      = 32'hBBBB;
        bus.stage_data   = {32'h2222, 32'hDEAD, 32'h10};
        bus.ex_redirect  = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_valid   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr, input logic ld);
        idle_inputs();
        bus.id_valid     = 1'b1;
        bus.id_rd        = rd;
        bus.id_reg_write = wr;
        bus.id_is_load   = ld;
    endtask

    task automatic consume(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2);
        issue(5'd20, 1'b1, 1'b0);
        bus.id_rs1      = rs1;
        bus.id_rs1_used = u1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = u2;
    endtask

    typedef struct {
        logic [4:0]  p_rd;
        logic        p_wr;
        logic        p_ld;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [31:0] e_a;
        logic        eh_a;
        logic [31:0] e_b;
        logic        eh_b;
        logic        e_hold;
    } vec_t;

    // Reference model: queue of in-flight destinations, index 0 = EX slot.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } ent_t;

    ent_t        pipe[$];
    bit          m_wait;
    int unsigned m_stall;

    task automatic model_clear();
        ent_t e;
        e = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
        pipe.delete();
        for (int i = 0; i < FWD_STAGES; i++) pipe.push_back(e);
        m_wait  = 1'b0;
        m_stall = 0;
    endtask

    task automatic model_fwd(input logic [4:0] rs, input logic used, input logic [31:0] idop,
                             output logic [31:0] op, output logic hit, output logic lu);
        op  = idop;
        hit = 1'b0;
        lu  = 1'b0;
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (pipe[i].v && pipe[i].wr && pipe[i].rd == rs && rs != 0 && used) begin
                if (pipe[i].ld && i < 1) lu = 1'b1;
                else if (!hit) begin
                    hit = 1'b1;
                    op  = bus.stage_data[i*32 +: 32];
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] ea, eb;
        logic        ha, hb, la, lb, efrz, eredir, ehold, ebub;
        ent_t        ne;

        // producer in slot 0 while the consumer sits in decode
        vecs[0] = '{5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 32'h10, 1'b1, 32'hBBBB, 1'b0, 1'b0};
        vecs[1] = '{5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 32'hAAAA, 1'b0, 32'hBBBB, 1'b0,
                    1'b0};
        vecs[2] = '{5'd7, 1'b1, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 32'hAAAA, 1'b0, 32'hBBBB, 1'b0,
                    1'b1};
        vecs[3] = '{5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 32'hAAAA, 1'b0, 32'hBBBB, 1'b0,
                    1'b0};
        vecs[4] = '{5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 32'hAAAA, 1'b0, 32'hBBBB, 1'b0,
                    1'b0};
        vecs[5] = '{5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0};

        // Reset state
        do_reset();
        consume(5'd5, 1'b1, 5'd6, 1'b1);
        #3;
        check("rst_freeze", 32'(bus.freeze), 32'd0);
        check("rst_hold", 32'(bus.hold_front), 32'd0);
        check("rst_bubble", 32'(bus.bubble_ex), 32'd0);
        check("rst_flush", 32'(bus.flush_front), 32'd0);
        check("rst_stall", bus.stall_cycles, 32'd0);
        check("rst_op_a", bus.op_a, 32'hAAAA);
        check("rst_hit_b", 32'(bus.fwd_hit_b), 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            issue(vecs[v].p_rd, vecs[v].p_wr, vecs[v].p_ld);
            step();
            consume(vecs[v].rs1, vecs[v].u1, vecs[v].rs2, vecs[v].u2);
            #3;
            check($sformatf("vec%0d_op_a", v), bus.op_a, vecs[v].e_a);
            check($sformatf("vec%0d_hit_a", v), 32'(bus.fwd_hit_a), 32'(vecs[v].eh_a));
            check($sformatf("vec%0d_op_b", v), bus.op_b, vecs[v].e_b);
            check($sformatf("vec%0d_hit_b", v), 32'(bus.fwd_hit_b), 32'(vecs[v].eh_b));
            check($sformatf("vec%0d_hold", v), 32'(bus.hold_front), 32'(vecs[v].e_hold));
        end

        // Load-use: one stall cycle, then forward from MEM
        do_reset();
        issue(5'd7, 1'b1, 1'b1);
        step();
        consume(5'd7, 1'b1, 5'd0, 1'b0);
        #3;
        check("lu_hold", 32'(bus.hold_front), 32'd1);
        check("lu_bubble", 32'(bus.bubble_ex), 32'd1);
        step();
        #3;
        check("lu_hold_next", 32'(bus.hold_front), 32'd0);
        check("lu_op_a", bus.op_a, 32'hDEAD);
        check("lu_hit_a", 32'(bus.fwd_hit_a), 32'd1);
        check("lu_stall", bus.stall_cycles, 32'd1);

        // Redirect with load-use in the same cycle
        do_reset();
        issue(5'd7, 1'b1, 1'b1);
        step();
        consume(5'd7, 1'b1, 5'd0, 1'b0);
        bus.id_rd       = 5'd6;
        bus.ex_redirect = 1'b1;
        #3;
        check("rd_flush", 32'(bus.flush_front), 32'd1);
        check("rd_bubble", 32'(bus.bubble_ex), 32'd1);
        check("rd_hold", 32'(bus.hold_front), 32'd0);
        step();
        consume(5'd6, 1'b1, 5'd7, 1'b1);
        #3;
        check("rd_slot0_invalid", 32'(bus.fwd_hit_a), 32'd0);
        check("rd_load_in_mem", bus.op_b, 32'hDEAD);

        // Data-memory wait: three frozen cycles, redirect deferred
        do_reset();
        issue(5'd5, 1'b1, 1'b0);
        step();
        consume(5'd5, 1'b1, 5'd0, 1'b0);
        bus.id_valid = 1'b0;
        bus.dmem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) bus.ex_redirect = 1'b1;
            #3;
            check($sformatf("wait%0d_freeze", c), 32'(bus.freeze), 32'd1);
            check($sformatf("wait%0d_op_a", c), bus.op_a, 32'h10);
            check($sformatf("wait%0d_flush", c), 32'(bus.flush_front), 32'd0);
            step();
        end
        bus.dmem_valid = 1'b1;
        #3;
        check("wait_done_freeze", 32'(bus.freeze), 32'd0);
        check("wait_done_flush", 32'(bus.flush_front), 32'd1);
        check("wait_done_stall", bus.stall_cycles, 32'd3);
        check("wait_done_op_a", bus.op_a, 32'h10);

        // Reset while in WAIT
        do_reset();
        issue(5'd5, 1'b1, 1'b0);
        bus.dmem_req = 1'b1;
        step();
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        consume(5'd5, 1'b1, 5'd5, 1'b1);
        #3;
        check("rstw_freeze", 32'(bus.freeze), 32'd0);
        check("rstw_stall", bus.stall_cycles, 32'd0);
        check("rstw_hit_a", 32'(bus.fwd_hit_a), 32'd0);
        check("rstw_hit_b", 32'(bus.fwd_hit_b), 32'd0);

        // Randomized traffic against the model
        do_reset();
        model_clear();
        for (int c = 0; c < 400; c++) begin
            rst              = ($urandom_range(63) == 0);
            bus.id_valid     = 1'($urandom_range(1));
            bus.id_rs1       = 5'($urandom_range(3));
            bus.id_rs2       = 5'($urandom_range(3));
            bus.id_rs1_used  = 1'($urandom_range(1));
            bus.id_rs2_used  = 1'($urandom_range(1));
            bus.id_rd        = 5'($urandom_range(3));
            bus.id_reg_write = 1'($urandom_range(1));
            bus.id_is_load   = ($urandom_range(2) == 0);
            bus.id_op_a      = $urandom;
            bus.id_op_b      = $urandom;
            bus.stage_data   = {$urandom, $urandom, $urandom};
            bus.ex_redirect  = ($urandom_range(7) == 0);
            bus.dmem_req     = ($urandom_range(3) == 0);
            bus.dmem_valid   = 1'($urandom_range(1));
            #3;
            model_fwd(bus.id_rs1, bus.id_rs1_used, bus.id_op_a, ea, ha, la);
            model_fwd(bus.id_rs2, bus.id_rs2_used, bus.id_op_b, eb, hb, lb);
            efrz   = m_wait ? !bus.dmem_valid : (bus.dmem_req && !bus.dmem_valid);
            eredir = bus.ex_redirect && !efrz;
            ehold  = (la || lb) && !eredir && !efrz;
            ebub   = ehold || eredir;
            check("rnd_op_a", bus.op_a, ea);
            check("rnd_op_b", bus.op_b, eb);
            check("rnd_hits", {30'd0, bus.fwd_hit_a, bus.fwd_hit_b}, {30'd0, ha, hb});
            check("rnd_ctrl", {28'd0, bus.freeze, bus.flush_front, bus.hold_front, bus.bubble_ex},
                  {28'd0, efrz, eredir, ehold, ebub});
            check("rnd_stall", bus.stall_cycles, m_stall);
            @(posedge clk);
            if (rst) begin
                model_clear();
            end else begin
                if (!efrz) begin
                    ne.v  = bus.id_valid && !ebub;
                    ne.rd = ne.v ? bus.id_rd : 5'd0;
                    ne.wr = ne.v && bus.id_reg_write;
                    ne.ld = ne.v && bus.id_is_load;
                    pipe.push_front(ne);
                    void'(pipe.pop_back());
                end
                m_wait = m_wait ? !bus.dmem_valid : (bus.dmem_req && !bus.dmem_valid);
                if ((ehold || efrz) && m_stall != 32'hFFFF_FFFF) m_stall++;
            end
            #1;
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
